// File: rtl/cci_mpf_prim_ram_dualport_be_init_pkg.sv
// Shared helpers for the MPF byte-enabled RAM primitives: byte counting and
// byte-lane merging of an old word with new write data.
package cci_mpf_prim_ram_pkg;

    // Widest word the generic merge helper handles; callers cast to their width.
    localparam int MAX_DATA_BITS = 512;

    function automatic int n_bytes(input int data_bits, input int byte_bits);
        return data_bits / byte_bits;
    endfunction

    function automatic logic [MAX_DATA_BITS-1:0] merge_bytes(
        input logic [MAX_DATA_BITS-1:0] old_data,
        input logic [MAX_DATA_BITS-1:0] new_data,
        input logic [MAX_DATA_BITS-1:0] be,
        input int                       byte_bits
    );
        logic [MAX_DATA_BITS-1:0] result;
        result = old_data;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (be[i / byte_bits]) begin
                result[i] = new_data[i];
            end else begin
                result[i] = old_data[i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cci_mpf_prim_ram_dualport_be_init_if.sv
// Port bundle of the dual-port byte-enabled RAM: both user ports, their read
// data and the init-complete flag.
interface cci_mpf_prim_ram_dualport_be_init_if
    import cci_mpf_prim_ram_pkg::*;
#(
    parameter int N_ENTRIES   = 32,
    parameter int N_DATA_BITS = 64,
    parameter int N_BYTE_BITS = 8
);
    localparam int A_BITS  = $clog2(N_ENTRIES);
    localparam int N_BYTES = n_bytes(N_DATA_BITS, N_BYTE_BITS);

    logic                   rdy;
    logic [A_BITS-1:0]      addr0;
    logic                   wen0;
    logic [N_BYTES-1:0]     byteena0;
    logic [N_DATA_BITS-1:0] wdata0;
    logic [N_DATA_BITS-1:0] rdata0;
    logic [A_BITS-1:0]      addr1;
    logic                   wen1;
    logic [N_BYTES-1:0]     byteena1;
    logic [N_DATA_BITS-1:0] wdata1;
    logic [N_DATA_BITS-1:0] rdata1;

    modport master (
        output addr0, wen0, byteena0, wdata0,
        output addr1, wen1, byteena1, wdata1,
        input  rdata0, rdata1, rdy
    );

    modport slave (
        input  addr0, wen0, byteena0, wdata0,
        input  addr1, wen1, byteena1, wdata1,
        output rdata0, rdata1, rdy
    );
endinterface

// File: rtl/cci_mpf_prim_ram_dualport_be_core.sv
// Raw byte-enabled dual-port storage with one registered read stage. Reads
// return the pre-write contents on any collision; port 1 wins shared bytes.
module cci_mpf_prim_ram_dualport_be_core
    import cci_mpf_prim_ram_pkg::*;
#(
    parameter int N_ENTRIES   = 32,
    parameter int N_DATA_BITS = 64,
    parameter int N_BYTE_BITS = 8
)(
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [$clog2(N_ENTRIES)-1:0]                  addr0,
    input  logic                                          wen0,
    input  logic [n_bytes(N_DATA_BITS, N_BYTE_BITS)-1:0]  be0,
    input  logic [N_DATA_BITS-1:0]                        wdata0,
    input  logic [$clog2(N_ENTRIES)-1:0]                  addr1,
    input  logic                                          wen1,
    input  logic [n_bytes(N_DATA_BITS, N_BYTE_BITS)-1:0]  be1,
    input  logic [N_DATA_BITS-1:0]                        wdata1,
    output logic [N_DATA_BITS-1:0]                        rdata0,
    output logic [N_DATA_BITS-1:0]                        rdata1
);
    localparam int N_BYTES = n_bytes(N_DATA_BITS, N_BYTE_BITS);

    logic [N_DATA_BITS-1:0] mem_r [N_ENTRIES];
    logic [N_DATA_BITS-1:0] rdata0_r;
    logic [N_DATA_BITS-1:0] rdata1_r;

    // Byte-lane writes; port 1 is applied last so it owns doubly-enabled bytes.
    always_ff @(posedge clk) begin
        for (int b = 0; b < N_BYTES; b++) begin
            if (wen0 && be0[b]) begin
                mem_r[addr0][b*N_BYTE_BITS +: N_BYTE_BITS] <= wdata0[b*N_BYTE_BITS +: N_BYTE_BITS];
            end
        end
        for (int b = 0; b < N_BYTES; b++) begin
            if (wen1 && be1[b]) begin
                mem_r[addr1][b*N_BYTE_BITS +: N_BYTE_BITS] <= wdata1[b*N_BYTE_BITS +: N_BYTE_BITS];
            end
        end
    end

    // Registered read stage of both ports.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata0_r <= '0;
            rdata1_r <= '0;
        end else begin
            rdata0_r <= mem_r[addr0];
            rdata1_r <= mem_r[addr1];
        end
    end

    assign rdata0 = rdata0_r;
    assign rdata1 = rdata1_r;
endmodule

// File: rtl/cci_mpf_prim_ram_dualport_be_init.sv
// Dual-port byte-enabled RAM with reset-time fill to INIT_VALUE, deterministic
// read-during-write forwarding on and across ports, and optional output stages.
module cci_mpf_prim_ram_dualport_be_init
    import cci_mpf_prim_ram_pkg::*;
#(
    parameter int                        N_ENTRIES           = 32,
    parameter int                        N_DATA_BITS         = 64,
    parameter int                        N_BYTE_BITS         = 8,
    parameter int                        N_OUTPUT_REG_STAGES = 0,
    parameter logic [N_DATA_BITS-1:0]    INIT_VALUE          = N_DATA_BITS'(0)
)(
    input  logic clk,
    input  logic reset,
    cci_mpf_prim_ram_dualport_be_init_if.slave ram
);
    localparam int A_BITS  = $clog2(N_ENTRIES);
    localparam int N_BYTES = n_bytes(N_DATA_BITS, N_BYTE_BITS);

    typedef logic [N_DATA_BITS-1:0] data_t;
    typedef logic [N_BYTES-1:0]     be_t;
    typedef logic [A_BITS-1:0]      addr_t;

    if ((N_DATA_BITS % N_BYTE_BITS) != 0) begin : g_bad_byte_width
        $fatal(1, "N_DATA_BITS must be a multiple of N_BYTE_BITS");
    end
    if ((N_ENTRIES < 2) || ((N_ENTRIES & (N_ENTRIES - 1)) != 0)) begin : g_bad_entries
        $fatal(1, "N_ENTRIES must be a power of 2 and at least 2");
    end
    if (N_DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_width
        $fatal(1, "N_DATA_BITS exceeds the merge helper width");
    end

    function automatic data_t merge_n(input data_t old_data, input data_t new_data, input be_t be);
        return data_t'(merge_bytes(MAX_DATA_BITS'(old_data), MAX_DATA_BITS'(new_data),
                                   MAX_DATA_BITS'(be), N_BYTE_BITS));
    endfunction

    logic  rdy_r;
    addr_t init_addr_r;

    // Init sequencer: one INIT_VALUE write per cycle, rdy once the last entry is done.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_r       <= 1'b0;
            init_addr_r <= '0;
        end else if (!rdy_r) begin
            if (init_addr_r == A_BITS'(N_ENTRIES - 1)) begin
                rdy_r <= 1'b1;
            end else begin
                init_addr_r <= init_addr_r + A_BITS'(1);
            end
        end else begin
            rdy_r       <= rdy_r;
            init_addr_r <= init_addr_r;
        end
    end

    addr_t core_addr0_s, core_addr1_s;
    logic  core_wen0_s, core_wen1_s;
    be_t   core_be0_s, core_be1_s;
    data_t core_wdata0_s, core_wdata1_s;

    // Port gating: init owns port 0 until rdy, user writes blocked meanwhile.
    always_comb begin
        core_addr0_s  = ram.addr0;
        core_wen0_s   = 1'b0;
        core_be0_s    = ram.byteena0;
        core_wdata0_s = ram.wdata0;
        core_addr1_s  = ram.addr1;
        core_wen1_s   = 1'b0;
        core_be1_s    = ram.byteena1;
        core_wdata1_s = ram.wdata1;
        if (reset) begin
            core_wen0_s = 1'b0;
        end else if (!rdy_r) begin
            core_addr0_s  = init_addr_r;
            core_wen0_s   = 1'b1;
            core_be0_s    = '1;
            core_wdata0_s = INIT_VALUE;
        end else begin
            core_wen0_s = ram.wen0;
            core_wen1_s = ram.wen1;
        end
    end

    data_t core_rdata0_s, core_rdata1_s;

    cci_mpf_prim_ram_dualport_be_core #(
        .N_ENTRIES   (N_ENTRIES),
        .N_DATA_BITS (N_DATA_BITS),
        .N_BYTE_BITS (N_BYTE_BITS)
    ) core (
        .clk    (clk),
        .reset  (reset),
        .addr0  (core_addr0_s),
        .wen0   (core_wen0_s),
        .be0    (core_be0_s),
        .wdata0 (core_wdata0_s),
        .addr1  (core_addr1_s),
        .wen1   (core_wen1_s),
        .be1    (core_be1_s),
        .wdata1 (core_wdata1_s),
        .rdata0 (core_rdata0_s),
        .rdata1 (core_rdata1_s)
    );

    addr_t f_addr0_r, f_addr1_r;
    logic  f_wen0_r, f_wen1_r;
    be_t   f_be0_r, f_be1_r;
    data_t f_wdata0_r, f_wdata1_r;

    // Capture last cycle's effective accesses to patch the raw read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_addr0_r  <= '0;
            f_addr1_r  <= '0;
            f_wen0_r   <= 1'b0;
            f_wen1_r   <= 1'b0;
            f_be0_r    <= '0;
            f_be1_r    <= '0;
            f_wdata0_r <= '0;
            f_wdata1_r <= '0;
        end else begin
            f_addr0_r  <= core_addr0_s;
            f_addr1_r  <= core_addr1_s;
            f_wen0_r   <= core_wen0_s;
            f_wen1_r   <= core_wen1_s;
            f_be0_r    <= core_be0_s;
            f_be1_r    <= core_be1_s;
            f_wdata0_r <= core_wdata0_s;
            f_wdata1_r <= core_wdata1_s;
        end
    end

    data_t mid0_s, mid1_s, fwd0_s, fwd1_s;

    // Apply port 0's write then port 1's, so port 1 wins shared bytes as in the array.
    always_comb begin
        mid0_s = f_wen0_r ? merge_n(core_rdata0_s, f_wdata0_r, f_be0_r) : core_rdata0_s;
        fwd0_s = (f_wen1_r && (f_addr1_r == f_addr0_r)) ? merge_n(mid0_s, f_wdata1_r, f_be1_r) : mid0_s;
        mid1_s = (f_wen0_r && (f_addr0_r == f_addr1_r)) ? merge_n(core_rdata1_s, f_wdata0_r, f_be0_r) : core_rdata1_s;
        fwd1_s = f_wen1_r ? merge_n(mid1_s, f_wdata1_r, f_be1_r) : mid1_s;
    end

    data_t rdata0_s, rdata1_s;

    if (N_OUTPUT_REG_STAGES == 0) begin : g_no_out_reg
        assign rdata0_s = fwd0_s;
        assign rdata1_s = fwd1_s;
    end else begin : g_out_reg
        data_t pipe0_r [N_OUTPUT_REG_STAGES];
        data_t pipe1_r [N_OUTPUT_REG_STAGES];

        // Output shift registers, cleared so rdata reads 0 until data flows through.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < N_OUTPUT_REG_STAGES; i++) begin
                    pipe0_r[i] <= '0;
                    pipe1_r[i] <= '0;
                end
            end else begin
                pipe0_r[0] <= fwd0_s;
                pipe1_r[0] <= fwd1_s;
                for (int i = 1; i < N_OUTPUT_REG_STAGES; i++) begin
                    pipe0_r[i] <= pipe0_r[i-1];
                    pipe1_r[i] <= pipe1_r[i-1];
                end
            end
        end

        assign rdata0_s = pipe0_r[N_OUTPUT_REG_STAGES-1];
        assign rdata1_s = pipe1_r[N_OUTPUT_REG_STAGES-1];
    end

    assign ram.rdy    = rdy_r;
    assign ram.rdata0 = rdata0_s;
    assign ram.rdata1 = rdata1_s;
endmodule

// File: tb/tb_cci_mpf_prim_ram_dualport_be_init.sv
// Scoreboard bench: two RAM instances (no output stage / INIT DEAD_BEEF, two
// output stages / INIT 0) driven identically and checked against a word model.
module tb_cci_mpf_prim_ram_dualport_be_init;
    localparam int N  = 32;
    localparam logic [63:0] INIT_A = 64'hDEAD_BEEF;
    localparam logic [63:0] INIT_B = 64'h0;
    localparam int LAT_A = 0;
    localparam int LAT_B = 2;

    typedef struct {
        int          due;
        logic [63:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   ecount = 0;
    int   total = 0;
    int   bad = 0;

    exp_t qa0[$], qa1[$], qb0[$], qb1[$], qrdy[$];
    logic [63:0] mem_a [N];
    logic [63:0] mem_b [N];
    int   init_cnt = 0;
    exp_t e_m;

    cci_mpf_prim_ram_dualport_be_init_if #(.N_ENTRIES(N), .N_DATA_BITS(64), .N_BYTE_BITS(8)) ifa ();
    cci_mpf_prim_ram_dualport_be_init_if #(.N_ENTRIES(N), .N_DATA_BITS(64), .N_BYTE_BITS(8)) ifb ();

    cci_mpf_prim_ram_dualport_be_init #(
        .N_ENTRIES(N), .N_DATA_BITS(64), .N_BYTE_BITS(8),
        .N_OUTPUT_REG_STAGES(LAT_A), .INIT_VALUE(INIT_A)
    ) dut_a (.clk(clk), .reset(reset), .ram(ifa));

    cci_mpf_prim_ram_dualport_be_init #(
        .N_ENTRIES(N), .N_DATA_BITS(64), .N_BYTE_BITS(8),
        .N_OUTPUT_REG_STAGES(LAT_B), .INIT_VALUE(INIT_B)
    ) dut_b (.clk(clk), .reset(reset), .ram(ifb));

    always #5 clk = ~clk;

    always @(posedge clk) ecount <= ecount + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s at edge %0d: got %h expected %h", nm, ecount, act, exp_v);
        end
    endtask

    // Monitor: compare each output whose expected value is due after this edge.
    always @(negedge clk) begin
        if (qa0.size() > 0 && qa0[0].due == ecount) begin e_m = qa0.pop_front(); check("a_rdata0", ifa.rdata0, e_m.val); end
        if (qa1.size() > 0 && qa1[0].due == ecount) begin e_m = qa1.pop_front(); check("a_rdata1", ifa.rdata1, e_m.val); end
        if (qb0.size() > 0 && qb0[0].due == ecount) begin e_m = qb0.pop_front(); check("b_rdata0", ifb.rdata0, e_m.val); end
        if (qb1.size() > 0 && qb1[0].due == ecount) begin e_m = qb1.pop_front(); check("b_rdata1", ifb.rdata1, e_m.val); end
        if (qrdy.size() > 0 && qrdy[0].due == ecount) begin
            e_m = qrdy.pop_front();
            check("a_rdy", 64'(ifa.rdy), e_m.val);
            check("b_rdy", 64'(ifb.rdy), e_m.val);
        end
    end

    function automatic logic [63:0] wr_word(input logic [63:0] old_w, input logic [63:0] new_w, input logic [7:0] be);
        logic [63:0] r;
        r = old_w;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    // One cycle of stimulus plus the expected consequences for both instances.
    task automatic drive(input logic r,
                         input logic [4:0] a0, input logic w0, input logic [7:0] b0, input logic [63:0] d0,
                         input logic [4:0] a1, input logic w1, input logic [7:0] b1, input logic [63:0] d1);
        int k;
        @(posedge clk);
        #1;
        reset = r;
        ifa.addr0 = a0; ifa.wen0 = w0; ifa.byteena0 = b0; ifa.wdata0 = d0;
        ifa.addr1 = a1; ifa.wen1 = w1; ifa.byteena1 = b1; ifa.wdata1 = d1;
        ifb.addr0 = a0; ifb.wen0 = w0; ifb.byteena0 = b0; ifb.wdata0 = d0;
        ifb.addr1 = a1; ifb.wen1 = w1; ifb.byteena1 = b1; ifb.wdata1 = d1;
        k = ecount + 1;
        if (r) begin
            init_cnt = 0;
            // Reset discards anything still in flight and forces outputs to zero.
            while (qa0.size() > 0 && qa0[$].due >= k) qa0.pop_back();
            while (qa1.size() > 0 && qa1[$].due >= k) qa1.pop_back();
            while (qb0.size() > 0 && qb0[$].due >= k) qb0.pop_back();
            while (qb1.size() > 0 && qb1[$].due >= k) qb1.pop_back();
            qa0.push_back('{k, 64'h0}); qa1.push_back('{k, 64'h0});
            qb0.push_back('{k, 64'h0}); qb1.push_back('{k, 64'h0});
            qrdy.push_back('{k, 64'h0});
        end else if (init_cnt < N) begin
            mem_a[init_cnt] = INIT_A;
            mem_b[init_cnt] = INIT_B;
            init_cnt++;
            qrdy.push_back('{k, (init_cnt == N) ? 64'h1 : 64'h0});
        end else begin
            mem_a[a0] = wr_word(mem_a[a0], d0, w0 ? b0 : 8'h00);
            mem_a[a1] = wr_word(mem_a[a1], d1, w1 ? b1 : 8'h00);
            mem_b[a0] = wr_word(mem_b[a0], d0, w0 ? b0 : 8'h00);
            mem_b[a1] = wr_word(mem_b[a1], d1, w1 ? b1 : 8'h00);
            qrdy.push_back('{k, 64'h1});
            qa0.push_back('{k + LAT_A, mem_a[a0]});
            qa1.push_back('{k + LAT_A, mem_a[a1]});
            qb0.push_back('{k + LAT_B, mem_b[a0]});
            qb1.push_back('{k + LAT_B, mem_b[a1]});
        end
    endtask

    task automatic drive_rand(input logic r, input int max_addr);
        logic [7:0] b0, b1;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        if ($urandom_range(0, 3) == 0) b0 = 8'hFF;
        if ($urandom_range(0, 5) == 0) b1 = 8'h00;
        drive(r, 5'($urandom_range(0, max_addr)), 1'($urandom_range(0, 1)), b0, {$urandom, $urandom},
                 5'($urandom_range(0, max_addr)), 1'($urandom_range(0, 1)), b1, {$urandom, $urandom});
    endtask

    task automatic sweep();
        for (int i = 0; i < N; i++) begin
            drive(1'b0, 5'(i), 1'b0, 8'h00, 64'h0, 5'(N - 1 - i), 1'b0, 8'h00, 64'h0);
        end
    endtask

    initial begin
        ifa.addr0 = '0; ifa.wen0 = 1'b0; ifa.byteena0 = '0; ifa.wdata0 = '0;
        ifa.addr1 = '0; ifa.wen1 = 1'b0; ifa.byteena1 = '0; ifa.wdata1 = '0;
        ifb.addr0 = '0; ifb.wen0 = 1'b0; ifb.byteena0 = '0; ifb.wdata0 = '0;
        ifb.addr1 = '0; ifb.wen1 = 1'b0; ifb.byteena1 = '0; ifb.wdata1 = '0;

        // Reset and init with user writes active; they must not land.
        repeat (3) drive_rand(1'b1, 31);
        repeat (N) drive_rand(1'b0, 31);
        sweep();

        // Directed cases.
        drive(1'b0, 5'd5, 1'b1, 8'h03, 64'hFFFF_FFFF_FFFF_1234, 5'd0, 1'b0, 8'h00, 64'h0);
        drive(1'b0, 5'd0, 1'b0, 8'h00, 64'h0, 5'd5, 1'b0, 8'h00, 64'h0);
        drive(1'b0, 5'd7, 1'b1, 8'hFF, 64'hA5, 5'd7, 1'b0, 8'h00, 64'h0);
        drive(1'b0, 5'd3, 1'b1, 8'hFF, 64'h1111_1111_1111_1111, 5'd3, 1'b1, 8'h0F, 64'h2222_2222_2222_2222);
        drive(1'b0, 5'd3, 1'b0, 8'h00, 64'h0, 5'd3, 1'b0, 8'h00, 64'h0);
        drive(1'b0, 5'd9, 1'b1, 8'hFF, 64'h55, 5'd0, 1'b0, 8'h00, 64'h0);
        drive(1'b0, 5'd9, 1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 1'b0, 8'h00, 64'h0);
        drive(1'b0, 5'd9, 1'b0, 8'h00, 64'h0, 5'd9, 1'b0, 8'h00, 64'h0);

        // Random traffic on a narrow address range to provoke collisions.
        repeat (300) drive_rand(1'b0, 7);

        // Reset from ready, reset again ten cycles into init, full re-init.
        repeat (2) drive_rand(1'b1, 31);
        repeat (10) drive_rand(1'b0, 31);
        drive_rand(1'b1, 31);
        repeat (N) drive_rand(1'b0, 31);
        sweep();
        repeat (100) drive_rand(1'b0, 31);

        repeat (6) @(negedge clk);
        check("queues_drained", 64'(qa0.size() + qa1.size() + qb0.size() + qb1.size() + qrdy.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
